// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage MIPS pipeline.
// Produces EX-stage forwarding selects, the IF/ID flush, load-use and
// ID-branch stall controls, and a whole-pipeline freeze while a
// multi-cycle data-memory access is outstanding.
// Optional performance counters are enabled by defining HAZ_PERF_CNT_EN.
module pipe_hazard_ctrl #(
    parameter int STALL_W     = 2,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_branch,
    input  logic       id_jr,
    input  logic       id_jump,
    input  logic       id_zero,
    input  logic [4:0] ex_rs,
    input  logic [4:0] ex_rt,
    input  logic       ex_memread,
    input  logic       ex_regwrite,
    input  logic [4:0] ex_writereg,
    input  logic       mem_regwrite,
    input  logic [4:0] mem_writereg,
    input  logic       wb_regwrite,
    input  logic [4:0] wb_writereg,
    input  logic       dmem_req,
    input  logic       dmem_ready,
    output logic [1:0] dfasel,
    output logic [1:0] dfbsel,
    output logic       flush,
    output logic       hold_if,
    output logic       bubble_ex,
    output logic       freeze,
    output logic       mem_err
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] freeze_cnt
`endif
);

    localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    typedef enum logic [1:0] {RUN, STALL, MEMWAIT} state_t;

    state_t             state_q, state_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               err_q, err_d;

    logic [STALL_W-1:0] haz_cnt;
    logic               hold_c, flush_c, freeze_c;
    logic [1:0]         fwd_a, fwd_b;
    logic               mem_busy, bj;

    // A source register in ID matches a producer (r0 never matches)
    function automatic logic id_match(input logic [4:0] r, input logic [4:0] rs,
                                      input logic [4:0] rt);
        return (r != 5'd0) && ((r == rs) || (r == rt));
    endfunction

    // Forwarding select for one EX operand; the younger MEM result wins over WB
    function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic mrw,
                                           input logic [4:0] mwr, input logic wrw,
                                           input logic [4:0] wwr);
        if (mrw && (mwr != 5'd0) && (mwr == src))      return 2'b01;
        else if (wrw && (wwr != 5'd0) && (wwr == src)) return 2'b10;
        else                                           return 2'b00;
    endfunction

    // Forwarding selects and hazard stall length from the current pipeline contents
    always_comb begin
        fwd_a    = fwd_sel(ex_rs, mem_regwrite, mem_writereg, wb_regwrite, wb_writereg);
        fwd_b    = fwd_sel(ex_rt, mem_regwrite, mem_writereg, wb_regwrite, wb_writereg);
        mem_busy = dmem_req && !dmem_ready;
        bj       = id_branch || id_jr;
        haz_cnt  = '0;
        if (bj && ex_memread && id_match(ex_writereg, id_rs, id_rt))
            haz_cnt = STALL_W'(2);
        else if ((ex_memread && id_match(ex_writereg, id_rs, id_rt)) ||
                 (bj && ex_regwrite && !ex_memread && id_match(ex_writereg, id_rs, id_rt)) ||
                 (bj && mem_regwrite && dmem_req && id_match(mem_writereg, id_rs, id_rt)))
            haz_cnt = STALL_W'(1);
    end

    // Sequencing FSM: next state, counters and per-cycle pipeline controls
    always_comb begin
        state_d  = state_q;
        stall_d  = stall_q;
        tmo_d    = tmo_q;
        err_d    = err_q;
        hold_c   = 1'b0;
        flush_c  = 1'b0;
        freeze_c = 1'b0;
        case (state_q)
            RUN: begin
                if (mem_busy) begin
                    // The entry cycle already freezes and counts toward the timeout
                    freeze_c = 1'b1;
                    tmo_d    = TMO_W'(1);
                    state_d  = MEMWAIT;
                end else if (haz_cnt != '0) begin
                    hold_c  = 1'b1;
                    stall_d = haz_cnt - STALL_W'(1);
                    if (stall_d != '0) state_d = STALL;
                end else if (id_jump || id_jr || (id_branch && id_zero)) begin
                    flush_c = 1'b1;
                end
            end
            STALL: begin
                if (mem_busy) begin
                    // Stall counter is held so the stall resumes after the access
                    freeze_c = 1'b1;
                    tmo_d    = TMO_W'(1);
                    state_d  = MEMWAIT;
                end else if (stall_q != '0) begin
                    hold_c  = 1'b1;
                    stall_d = stall_q - STALL_W'(1);
                    if (stall_d == '0) state_d = RUN;
                end else begin
                    state_d = RUN;
                end
            end
            MEMWAIT: begin
                if (dmem_ready) begin
                    tmo_d   = '0;
                    state_d = (stall_q != '0) ? STALL : RUN;
                end else begin
                    freeze_c = 1'b1;
                    if (tmo_q >= TMO_W'(MEM_TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        tmo_d   = '0;
                        stall_d = '0;
                        state_d = RUN;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Controller state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            stall_q <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    // Outputs are forced low while reset is asserted, including the combinational ones
    assign dfasel    = rst ? 2'b00 : fwd_a;
    assign dfbsel    = rst ? 2'b00 : fwd_b;
    assign flush     = flush_c  && !rst;
    assign hold_if   = hold_c   && !rst;
    assign bubble_ex = hold_c   && !rst;
    assign freeze    = freeze_c && !rst;
    assign mem_err   = err_q;

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, freeze_cnt_q;

    // Saturating event counters for stall, flush and freeze cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            freeze_cnt_q <= '0;
        end else begin
            if (hold_if && !(&stall_cnt_q))  stall_cnt_q  <= stall_cnt_q + CNT_W'(1);
            if (flush && !(&flush_cnt_q))    flush_cnt_q  <= flush_cnt_q + CNT_W'(1);
            if (freeze && !(&freeze_cnt_q))  freeze_cnt_q <= freeze_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;
    assign freeze_cnt = freeze_cnt_q;
`endif

endmodule
